// File: rtl/pwm_gen_multi.sv
// pwm_gen_multi: multi-channel PWM generator sharing one free-running period
// counter, with double-buffered (shadowed) period/mode/compare configuration.
// Optional feature macro: PWM_CENTER_ALIGN_EN builds center-aligned mode 11;
// without it mode 11 behaves as left-aligned and no center-bound logic exists.

module pwm_gen_multi #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pwm_en,
    input  logic [WIDTH-1:0]          period,
    input  logic [2*CHANNELS-1:0]     functions,
    input  logic [CHANNELS*WIDTH-1:0] compare1,
    input  logic [CHANNELS*WIDTH-1:0] compare2,
    input  logic                      update_req,
    output logic                      update_pending,
    output logic [WIDTH-1:0]          count_val,
    output logic                      period_tick,
    output logic [CHANNELS-1:0]       pwm_out
);

    // Active (working) copies of the configuration; channel logic reads only these.
    logic [WIDTH-1:0]          period_a;
    logic [2*CHANNELS-1:0]     functions_a;
    logic [CHANNELS*WIDTH-1:0] compare1_a;
    logic [CHANNELS*WIDTH-1:0] compare2_a;

    logic                      wrap;
    logic                      load;
    logic [CHANNELS-1:0]       pwm_nxt;

`ifdef PWM_CENTER_ALIGN_EN
    logic [CHANNELS-1:0][WIDTH:0] lo_a;
    logic [CHANNELS-1:0][WIDTH:0] hi_a;

    // Center window {hi, lo} in WIDTH+1 bits; a compare covering the whole
    // period saturates to the full window so the output stays high.
    function automatic logic [2*WIDTH+1:0] center_bounds(
        input logic [WIDTH-1:0] per,
        input logic [WIDTH-1:0] cmp
    );
        logic [WIDTH:0] span;
        logic [WIDTH:0] cmpx;
        logic [WIDTH:0] lo;
        logic [WIDTH:0] hi;
        span = {1'b0, per} + (WIDTH+1)'(1);
        cmpx = {1'b0, cmp};
        if (cmpx >= span) begin
            lo = '0;
            hi = span;
        end else begin
            lo = (span - cmpx) >> 1;
            hi = lo + cmpx;
        end
        return {hi, lo};
    endfunction
`endif

    // The wrap cycle is the period boundary; the tick is only meaningful while enabled.
    assign wrap        = pwm_en && (count_val == period_a);
    assign period_tick = wrap;

    // Disabled: track inputs continuously. Enabled: load only at the boundary,
    // either for a queued request or one arriving exactly on the wrap cycle.
    assign load = !pwm_en || (wrap && (update_pending || update_req));

    // Shadow-to-active transfer of period, modes and compares.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_a    <= '0;
            functions_a <= '0;
            compare1_a  <= '0;
            compare2_a  <= '0;
        end else if (load) begin
            period_a    <= period;
            functions_a <= functions;
            compare1_a  <= compare1;
            compare2_a  <= compare2;
        end
    end

`ifdef PWM_CENTER_ALIGN_EN
    // Center bounds are precomputed at load so the per-cycle compare is cheap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_a <= '0;
            hi_a <= '0;
        end else if (load) begin
            for (int i = 0; i < CHANNELS; i++) begin
                {hi_a[i], lo_a[i]} <= center_bounds(period, compare1[WIDTH*i +: WIDTH]);
            end
        end
    end
`endif

    // Pending flag: set by a request, cleared by the load that consumes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            update_pending <= 1'b0;
        end else if (load) begin
            update_pending <= 1'b0;
        end else if (update_req) begin
            update_pending <= 1'b1;
        end
    end

    // Shared timebase: counts 0..period_a, holds while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_val <= '0;
        end else if (pwm_en) begin
            count_val <= wrap ? '0 : count_val + WIDTH'(1);
        end
    end

    // Per-channel duty decision from the current count and the active compares.
    always_comb begin
        pwm_nxt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            case (functions_a[2*i +: 2])
                2'b01: pwm_nxt[i] = (count_val >= compare1_a[WIDTH*i +: WIDTH]);
                2'b10: pwm_nxt[i] = (count_val >= compare1_a[WIDTH*i +: WIDTH]) &&
                                    (count_val <  compare2_a[WIDTH*i +: WIDTH]);
`ifdef PWM_CENTER_ALIGN_EN
                2'b11: pwm_nxt[i] = ({1'b0, count_val} >= lo_a[i]) &&
                                    ({1'b0, count_val} <  hi_a[i]);
`endif
                default: pwm_nxt[i] = (count_val < compare1_a[WIDTH*i +: WIDTH]);
            endcase
        end
    end

    // Registered outputs, frozen while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out <= '0;
        end else if (pwm_en) begin
            pwm_out <= pwm_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_gen_multi.sv
// tb_pwm_gen_multi: directed plus randomized bench for pwm_gen_multi with an
// arithmetic reference model checked on every falling clock edge.

module tb_pwm_gen_multi;

    localparam int CH = 4;
    localparam int W  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            pwm_en;
    logic [W-1:0]    period;
    logic [2*CH-1:0] functions;
    logic [CH*W-1:0] compare1;
    logic [CH*W-1:0] compare2;
    logic            update_req;
    logic            update_pending;
    logic [W-1:0]    count_val;
    logic            period_tick;
    logic [CH-1:0]   pwm_out;

    pwm_gen_multi #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .pwm_en         (pwm_en),
        .period         (period),
        .functions      (functions),
        .compare1       (compare1),
        .compare2       (compare2),
        .update_req     (update_req),
        .update_pending (update_pending),
        .count_val      (count_val),
        .period_tick    (period_tick),
        .pwm_out        (pwm_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    longint    m_period;
    int        m_func [CH];
    longint    m_c1   [CH];
    longint    m_c2   [CH];
    longint    m_count;
    bit        m_pend;
    bit [CH-1:0] m_out;
    bit        m_tick;
    bit        m_load;

    // Is count c inside the high window of a channel with mode f?
    function automatic bit duty_high(int f, longint c, longint p, longint c1, longint c2);
        case (f)
            1: return c >= c1;
            2: return (c >= c1) && (c < c2);
            3: begin
`ifdef PWM_CENTER_ALIGN_EN
                longint lo;
                longint hi;
                if (c1 >= p + 1) begin
                    lo = 0;
                    hi = p + 1;
                end else begin
                    lo = (p + 1 - c1) / 2;
                    hi = lo + c1;
                end
                return (c >= lo) && (c < hi);
`else
                return c < c1;
`endif
            end
            default: return c < c1;
        endcase
    endfunction

    task automatic model_reset();
        m_period = 0;
        m_count  = 0;
        m_pend   = 1'b0;
        m_out    = '0;
        for (int i = 0; i < CH; i++) begin
            m_func[i] = 0;
            m_c1[i]   = 0;
            m_c2[i]   = 0;
        end
    endtask

    task automatic model_step();
        m_tick = pwm_en && (m_count == m_period);
        m_load = !pwm_en || (m_tick && (m_pend || update_req));
        if (pwm_en) begin
            for (int i = 0; i < CH; i++)
                m_out[i] = duty_high(m_func[i], m_count, m_period, m_c1[i], m_c2[i]);
            m_count = m_tick ? 0 : ((m_count + 1) & ((longint'(1) << W) - 1));
        end
        if (m_load) begin
            m_period = longint'(period);
            for (int i = 0; i < CH; i++) begin
                m_func[i] = int'(functions[2*i +: 2]);
                m_c1[i]   = longint'(compare1[W*i +: W]);
                m_c2[i]   = longint'(compare2[W*i +: W]);
            end
            m_pend = 1'b0;
        end else if (update_req) begin
            m_pend = 1'b1;
        end
    endtask

    // Model advance on the same edges as the DUT
    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("count_val",      64'(count_val),      64'(m_count));
            chk("pwm_out",        64'(pwm_out),        64'(m_out));
            chk("update_pending", 64'(update_pending), 64'(m_pend));
            chk("period_tick",    64'(period_tick),    64'(pwm_en && (m_count == m_period)));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_ch(input int i, input int f, input longint c1, input longint c2);
        functions[2*i +: 2] = 2'(f);
        compare1[W*i +: W]  = W'(c1);
        compare2[W*i +: W]  = W'(c2);
    endtask

    task automatic wait_count(input logic [W-1:0] v);
        int n;
        n = 0;
        while (count_val != v && n < 100) begin
            step(1);
            n++;
        end
        if (count_val != v) chk("wait_count_timeout", 64'(count_val), 64'(v));
    endtask

    task automatic apply_now();
        int n;
        update_req = 1'b1;
        step(1);
        update_req = 1'b0;
        n = 0;
        while (update_pending && n < 100) begin
            step(1);
            n++;
        end
        if (update_pending) chk("pending_timeout", 64'(update_pending), 64'd0);
    endtask

    // Bit k of mask = pwm_out[ch] for count k over one full 10-count period
    task automatic window(input int ch, output logic [9:0] mask, output logic [9:0] tmask);
        wait_count(0);
        step(1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            mask[k]  = pwm_out[ch];
            tmask[k] = period_tick;
            @(posedge clk);
            #2;
        end
    endtask

    logic [9:0] mask;
    logic [9:0] tmask;
    int         cnt;
    int         per;

    initial begin
        rst        = 1'b1;
        pwm_en     = 1'b0;
        period     = '0;
        functions  = '0;
        compare1   = '0;
        compare2   = '0;
        update_req = 1'b0;
        #1;
        chk("reset_count",   64'(count_val),      64'd0);
        chk("reset_pwm",     64'(pwm_out),        64'd0);
        chk("reset_pending", 64'(update_pending), 64'd0);
        chk("reset_tick",    64'(period_tick),    64'd0);
        step(1);
        rst = 1'b0;

        // Left-aligned ch0, period 9
        period = W'(9);
        set_ch(0, 0, 3, 0);
        step(1);
        pwm_en = 1'b1;
        window(0, mask, tmask);
        chk("left_mask", 64'(mask), 64'h007);
        chk("tick_mask", 64'(tmask), 64'h100);
        window(0, mask, tmask);
        chk("left_mask_2", 64'(mask), 64'h007);

        // Unaligned ch1 edge cases
        set_ch(1, 2, 2, 6);
        apply_now();
        window(1, mask, tmask);
        chk("unaligned_mask", 64'(mask), 64'h03C);
        set_ch(1, 2, 4, 4);
        apply_now();
        window(1, mask, tmask);
        chk("unaligned_equal", 64'(mask), 64'h000);
        set_ch(1, 2, 7, 3);
        apply_now();
        window(1, mask, tmask);
        chk("unaligned_inverted", 64'(mask), 64'h000);

        // Shadowing: change without request is ignored
        wait_count(4);
        set_ch(0, 0, 8, 0);
        step(1);
        chk("shadow_no_pending", 64'(update_pending), 64'd0);
        chk("shadow_hold",       64'(pwm_out[0]),     64'd0);
        update_req = 1'b1;
        step(1);
        update_req = 1'b0;
        chk("shadow_pending_set", 64'(update_pending), 64'd1);
        window(0, mask, tmask);
        chk("shadow_new_duty", 64'(mask), 64'h0FF);

        // Request on the wrap cycle loads at once
        set_ch(0, 0, 5, 0);
        wait_count(9);
        update_req = 1'b1;
        step(1);
        update_req = 1'b0;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            cnt += int'(update_pending);
            @(posedge clk);
            #2;
        end
        chk("wrap_req_no_pending", 64'(cnt), 64'd0);
        window(0, mask, tmask);
        chk("wrap_req_duty", 64'(mask), 64'h01F);

        // Mode 11 on ch2
        set_ch(2, 3, 4, 0);
        apply_now();
        window(2, mask, tmask);
`ifdef PWM_CENTER_ALIGN_EN
        chk("center_mask", 64'(mask), 64'h078);
`else
        chk("mode3_as_left", 64'(mask), 64'h00F);
`endif

        // Reset mid-period with an update pending
        wait_count(3);
        update_req = 1'b1;
        step(1);
        update_req = 1'b0;
        wait_count(5);
        chk("pending_before_rst", 64'(update_pending), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_count",   64'(count_val),      64'd0);
        chk("rst_mid_pwm",     64'(pwm_out),        64'd0);
        chk("rst_mid_pending", 64'(update_pending), 64'd0);
        step(1);
        rst = 1'b0;

        // Period 0: tick every enabled cycle
        pwm_en = 1'b0;
        period = '0;
        step(1);
        pwm_en = 1'b1;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            cnt += int'(period_tick);
            @(posedge clk);
            #2;
        end
        chk("period0_ticks", 64'(cnt), 64'd6);

        // Compare beyond period: always high
        pwm_en = 1'b0;
        period = W'(9);
        set_ch(0, 0, 10, 0);
        step(1);
        pwm_en = 1'b1;
        window(0, mask, tmask);
        chk("left_full_high", 64'(mask), 64'h3FF);

        // Randomized segments with a fixed period each
        for (int seg = 0; seg < 6; seg++) begin
            rst = 1'b1;
            step(1);
            rst = 1'b0;
            per = int'($urandom_range(0, 12));
            period = W'(per);
            pwm_en = 1'b0;
            for (int i = 0; i < CH; i++)
                set_ch(i, int'($urandom_range(0, 3)), longint'($urandom_range(0, per + 2)),
                       longint'($urandom_range(0, per + 2)));
            step(1);
            pwm_en = 1'b1;
            for (int k = 0; k < 250; k++) begin
                update_req = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 3) == 0)
                    set_ch(int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 3)),
                           longint'($urandom_range(0, per + 2)),
                           longint'($urandom_range(0, per + 2)));
                pwm_en = ($urandom_range(0, 9) != 0);
                step(1);
            end
            update_req = 1'b0;
            pwm_en     = 1'b1;
        end

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
